bsk_prm_bus_master: RTL and testbench

Synchronous bus master that sequences the 4-register parallel interface of one BSK PRM command-output unit.
- Writes two command words with complement-nibble protection, the indication word and the terminal-enable control byte.
- Reads back the command register and the status/ID register, verifies them and reports done/err.
- Sits between the CPU-side register file and the PRM strobed async bus, one instance per unit.

---
 rtl/bsk_prm_bus_master.sv | 222 ++++++++++++++++++++++
 tb/tb_bsk_prm_bus_master.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/bsk_prm_bus_master.sv
// Bus master for one BSK PRM command-output unit: four protected register writes, then two verified readbacks.
// Optional BSK_PRM_RETRY_EN: a failed verify reruns the whole sequence once before err is raised.
module bsk_prm_bus_master #(
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned STROBE_CYC = 4,
  parameter logic [3:0]  CS_CODE    = 4'b0111
) (
  input  logic        clk,
  input  logic        aclr,
  input  logic        start,
  input  logic        unit,
  input  logic [15:0] com_word,
  input  logic [15:0] ind_word,
  input  logic        enable_req,
  output logic [1:0]  bus_a,
  output logic [3:0]  bus_cs,
  output logic        bus_wr_n,
  output logic        bus_rd_n,
  output logic [15:0] bus_dout,
  output logic        bus_oe,
  input  logic [15:0] bus_din,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] status
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_STROBE = 3'd2;
  localparam logic [2:0] S_HOLD   = 3'd3;
  localparam logic [2:0] S_GAP    = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;

  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
  localparam logic [2:0] LAST_IDX  = 3'd5;

  logic [2:0]  state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic [2:0]  idx, idx_nx;
  logic [15:0] com_q, ind_q;
  logic        en_q, unit_q;
  logic        fail_q, fail_nx;
`ifdef BSK_PRM_RETRY_EN
  logic        retry_q, retry_nx;
`endif

  logic [1:0]  bus_a_nx;
  logic [3:0]  bus_cs_nx;
  logic        bus_wr_n_nx, bus_rd_n_nx, bus_oe_nx;
  logic [15:0] bus_dout_nx;
  logic        busy_nx, done_nx, err_nx;
  logic [15:0] status_nx;

  logic        take_c, active_c, rd_c;
  logic [15:0] com_c, ind_c;
  logic        en_c, unit_c;

  // Sequence inputs are taken straight from the ports on the accepting clock so the first SETUP drives them.
  assign take_c = (state == S_IDLE) && start;
  assign com_c  = take_c ? com_word   : com_q;
  assign ind_c  = take_c ? ind_word   : ind_q;
  assign en_c   = take_c ? enable_req : en_q;
  assign unit_c = take_c ? unit       : unit_q;

  // Next state plus next value of every registered output.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    idx_nx    = idx;
    fail_nx   = fail_q;
    err_nx    = err;
    status_nx = status;
    done_nx   = 1'b0;
`ifdef BSK_PRM_RETRY_EN
    retry_nx  = retry_q;
`endif

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = S_SETUP;
          cnt_nx   = SETUP_LD;
          idx_nx   = 3'd0;
          fail_nx  = 1'b0;
          err_nx   = 1'b0;
`ifdef BSK_PRM_RETRY_EN
          retry_nx = 1'b0;
`endif
        end
      end
      S_SETUP: begin
        if (cnt == 4'd0) begin
          state_nx = S_STROBE;
          cnt_nx   = STROBE_LD;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      S_STROBE: begin
        if (cnt == 4'd0) begin
          state_nx = S_HOLD;
          cnt_nx   = SETUP_LD;
          if (idx == 3'd4 && bus_din != com_q) fail_nx = 1'b1;
          if (idx == LAST_IDX) begin
            status_nx = bus_din;
            if (bus_din[15:8] != (8'hA6 + {7'd0, unit_q}) || bus_din[0] != en_q) fail_nx = 1'b1;
          end
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      S_HOLD: begin
        if (cnt != 4'd0) begin
          cnt_nx = cnt - 4'd1;
        end else if (idx != LAST_IDX) begin
          state_nx = S_GAP;
          idx_nx   = idx + 3'd1;
        end else begin
`ifdef BSK_PRM_RETRY_EN
          if (fail_q && !retry_q) begin
            state_nx = S_GAP;
            idx_nx   = 3'd0;
            fail_nx  = 1'b0;
            retry_nx = 1'b1;
          end else begin
            state_nx = S_FINISH;
            err_nx   = fail_q;
          end
`else
          state_nx = S_FINISH;
          err_nx   = fail_q;
`endif
        end
      end
      S_GAP: begin
        state_nx = S_SETUP;
        cnt_nx   = SETUP_LD;
      end
      S_FINISH: begin
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase

    if (state_nx == S_FINISH) done_nx = 1'b1;
    busy_nx  = (state_nx != S_IDLE) && (state_nx != S_FINISH);
    active_c = (state_nx == S_SETUP) || (state_nx == S_STROBE) || (state_nx == S_HOLD);
    rd_c     = (idx_nx >= 3'd4);

    bus_cs_nx   = 4'hF;
    bus_a_nx    = bus_a;
    bus_dout_nx = bus_dout;
    bus_oe_nx   = 1'b0;
    bus_wr_n_nx = 1'b1;
    bus_rd_n_nx = 1'b1;
    if (active_c) begin
      bus_cs_nx   = {CS_CODE[3:2], CS_CODE[1] ^ unit_c, CS_CODE[0]};
      bus_oe_nx   = !rd_c;
      bus_wr_n_nx = !((state_nx == S_STROBE) && !rd_c);
      bus_rd_n_nx = !((state_nx == S_STROBE) && rd_c);
      case (idx_nx)
        3'd0: begin bus_a_nx = 2'd0; bus_dout_nx = {com_c[7:4], ~com_c[7:4], com_c[3:0], ~com_c[3:0]}; end
        3'd1: begin bus_a_nx = 2'd1; bus_dout_nx = {com_c[15:12], ~com_c[15:12], com_c[11:8], ~com_c[11:8]}; end
        3'd2: begin bus_a_nx = 2'd2; bus_dout_nx = ind_c; end
        3'd3: begin bus_a_nx = 2'd3; bus_dout_nx = {8'h00, en_c ? 8'hE1 : 8'h00}; end
        3'd4: bus_a_nx = 2'd1;
        default: bus_a_nx = 2'd3;
      endcase
    end
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      idx      <= 3'd0;
      com_q    <= 16'd0;
      ind_q    <= 16'd0;
      en_q     <= 1'b0;
      unit_q   <= 1'b0;
      fail_q   <= 1'b0;
`ifdef BSK_PRM_RETRY_EN
      retry_q  <= 1'b0;
`endif
      bus_a    <= 2'd0;
      bus_cs   <= 4'hF;
      bus_wr_n <= 1'b1;
      bus_rd_n <= 1'b1;
      bus_dout <= 16'd0;
      bus_oe   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      status   <= 16'd0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      idx      <= idx_nx;
      com_q    <= com_c;
      ind_q    <= ind_c;
      en_q     <= en_c;
      unit_q   <= unit_c;
      fail_q   <= fail_nx;
`ifdef BSK_PRM_RETRY_EN
      retry_q  <= retry_nx;
`endif
      bus_a    <= bus_a_nx;
      bus_cs   <= bus_cs_nx;
      bus_wr_n <= bus_wr_n_nx;
      bus_rd_n <= bus_rd_n_nx;
      bus_dout <= bus_dout_nx;
      bus_oe   <= bus_oe_nx;
      busy     <= busy_nx;
      done     <= done_nx;
      err      <= err_nx;
      status   <= status_nx;
    end
  end

endmodule

// File: tb/tb_bsk_prm_bus_master.sv
// Scoreboard bench for bsk_prm_bus_master: a bus monitor pops expected transactions, a register model answers reads.
module tb_bsk_prm_bus_master;

  localparam int unsigned SC = 2;
  localparam int unsigned TC = 4;
  localparam logic [3:0]  CS = 4'b0111;

  logic        clk = 1'b0;
  logic        aclr, start, unit, enable_req;
  logic [15:0] com_word, ind_word, bus_din, bus_dout, status;
  logic [1:0]  bus_a;
  logic [3:0]  bus_cs;
  logic        bus_wr_n, bus_rd_n, bus_oe, busy, done, err;

  bsk_prm_bus_master #(.SETUP_CYC(SC), .STROBE_CYC(TC), .CS_CODE(CS)) dut (
    .clk(clk), .aclr(aclr), .start(start), .unit(unit), .com_word(com_word),
    .ind_word(ind_word), .enable_req(enable_req), .bus_a(bus_a), .bus_cs(bus_cs),
    .bus_wr_n(bus_wr_n), .bus_rd_n(bus_rd_n), .bus_dout(bus_dout), .bus_oe(bus_oe),
    .bus_din(bus_din), .busy(busy), .done(done), .err(err), .status(status)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic        rd;
    logic [1:0]  a;
    logic [3:0]  cs;
    logic [15:0] d;
  } txn_t;

  txn_t        exp_q[$];
  txn_t        cur;
  int          total = 0, bad = 0;
  int          seq_txn = 0, done_cnt = 0, rpass = 0, gap = 0, overlap = 0;
  int          pre = 0, lo = 0, post = 0, e0 = 0;
  logic        in_txn = 1'b0, abort = 1'b0;
  logic [15:0] m_a1 [2];
  logic [15:0] m_a3 [2];

  // Register model: the second pass of a retried sequence sees the second answer set.
  assign bus_din = (bus_a == 2'd1) ? ((rpass == 0) ? m_a1[0] : m_a1[1])
                                   : ((rpass == 0) ? m_a3[0] : m_a3[1]);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Watches the bus each falling edge: phase lengths, inter-transaction gap, strobe overlap, scoreboard.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (aclr) begin
        in_txn = 1'b0;
      end else begin
        if (!bus_wr_n && !bus_rd_n) overlap++;
        if (done) done_cnt++;
        if (bus_cs != 4'hF) begin
          if (!in_txn) begin
            if (seq_txn > 0) chk("gap_len", 32'(gap), 32'd1);
            in_txn = 1'b1;
            pre = 0; lo = 0; post = 0;
          end
          if (bus_wr_n && bus_rd_n) begin
            if (lo == 0) pre++; else post++;
          end else begin
            if (lo == 0) cur = {!bus_rd_n, bus_a, bus_cs, bus_rd_n ? bus_dout : 16'h0000};
            lo++;
          end
        end else begin
          if (in_txn) begin
            in_txn = 1'b0;
            gap = 0;
            seq_txn++;
            if (!abort) begin
              chk("setup_len", 32'(pre), 32'(SC));
              chk("strobe_len", 32'(lo), 32'(TC));
              chk("hold_len", 32'(post), 32'(SC));
              if (exp_q.size() == 0) chk("txn_extra", 32'd1, 32'd0);
              else chk("txn", 32'(cur), 32'(exp_q.pop_front()));
            end
            if (cur.rd && cur.a == 2'd3) rpass++;
          end
          gap++;
        end
      end
    end
  endtask

  task automatic push_txn(input logic rd, input logic [1:0] a, input logic [3:0] cs, input logic [15:0] d);
    txn_t t;
    t = {rd, a, cs, d};
    exp_q.push_back(t);
  endtask

  task automatic start_seq(input logic u, input logic [15:0] com, input logic [15:0] ind,
                           input logic en, input int npass);
    logic [3:0] cs;
    cs = {CS[3:2], CS[1] ^ u, CS[0]};
    seq_txn = 0; rpass = 0; abort = 1'b0;
    for (int p = 0; p < npass; p++) begin
      push_txn(1'b0, 2'd0, cs, {com[7:4], ~com[7:4], com[3:0], ~com[3:0]});
      push_txn(1'b0, 2'd1, cs, {com[15:12], ~com[15:12], com[11:8], ~com[11:8]});
      push_txn(1'b0, 2'd2, cs, ind);
      push_txn(1'b0, 2'd3, cs, en ? 16'h00E1 : 16'h0000);
      push_txn(1'b1, 2'd1, cs, 16'h0000);
      push_txn(1'b1, 2'd3, cs, 16'h0000);
    end
    @(negedge clk);
    unit = u; com_word = com; ind_word = ind; enable_req = en; start = 1'b1;
    e0 = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    // Scramble the ports so only the latched copies can produce correct bus data.
    com_word = ~com; ind_word = ~ind; enable_req = ~en; unit = ~u;
  endtask

  task automatic run_seq(input logic u, input logic [15:0] com, input logic [15:0] ind, input logic en,
                         input logic [15:0] a1p1, input logic [15:0] a3p1,
                         input logic [15:0] a1p2, input logic [15:0] a3p2,
                         input int npass, input bit restart, input logic exp_err);
    int  dcnt0, lat, ntx;
    bit  seen;
    m_a1[0] = a1p1; m_a3[0] = a3p1; m_a1[1] = a1p2; m_a3[1] = a3p2;
    dcnt0 = done_cnt;
    ntx = 6 * npass;
    seen = 1'b0;
    start_seq(u, com, ind, en, npass);
    for (int i = 0; i < 400 && !seen; i++) begin
      if (restart && i == 8) start = 1'b1; else start = 1'b0;
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        lat = cyc - e0 + 2;
        chk("latency", 32'(lat), 32'(ntx * (2 * SC + TC) + (ntx - 1) + 2));
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("err", 32'(err), 32'(exp_err));
        chk("status", 32'(status), 32'((npass == 1) ? a3p1 : a3p2));
      end
    end
    start = 1'b0;
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
    repeat (4) @(negedge clk);
    chk("done_count", 32'(done_cnt - dcnt0), 32'd1);
    chk("txn_count", 32'(seq_txn), 32'(ntx));
    chk("sb_left", 32'(exp_q.size()), 32'd0);
    chk("err_held", 32'(err), 32'(exp_err));
  endtask

  initial begin
    bit found;
    int dcnt0;
    aclr = 1'b1; start = 1'b0; unit = 1'b0; enable_req = 1'b0;
    com_word = 16'h0; ind_word = 16'h0;
    m_a1[0] = 16'h0; m_a1[1] = 16'h0; m_a3[0] = 16'h0; m_a3[1] = 16'h0;
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    chk("rst_cs", 32'(bus_cs), 32'hF);
    chk("rst_wr_n", 32'(bus_wr_n), 32'd1);
    chk("rst_rd_n", 32'(bus_rd_n), 32'd1);
    chk("rst_a_oe_dout", 32'({bus_a, bus_oe, bus_dout}), 32'd0);
    chk("rst_busy_done_err", 32'({busy, done, err}), 32'd0);
    chk("rst_status", 32'(status), 32'd0);
    aclr = 1'b0;
    repeat (2) @(negedge clk);

    run_seq(1'b0, 16'h00FF, 16'h1234, 1'b1, 16'h00FF, 16'hA6C5, 16'h00FF, 16'hA6C5, 1, 1'b0, 1'b0);
    run_seq(1'b1, 16'hA55A, 16'hBEEF, 1'b1, 16'hA55A, 16'hA7C5, 16'hA55A, 16'hA7C5, 1, 1'b0, 1'b0);
`ifdef BSK_PRM_RETRY_EN
    run_seq(1'b0, 16'h00FF, 16'h1234, 1'b1, 16'h00FE, 16'hA6C5, 16'h00FF, 16'hA6C5, 2, 1'b0, 1'b0);
    run_seq(1'b0, 16'h3C96, 16'h0F0F, 1'b1, 16'h3C96, 16'hA7C5, 16'h3C96, 16'hA6C4, 2, 1'b0, 1'b1);
`else
    run_seq(1'b0, 16'h00FF, 16'h1234, 1'b1, 16'h00FE, 16'hA6C5, 16'h00FF, 16'hA6C5, 1, 1'b0, 1'b1);
    run_seq(1'b0, 16'h3C96, 16'h0F0F, 1'b1, 16'h3C96, 16'hA7C5, 16'h3C96, 16'hA7C5, 1, 1'b0, 1'b1);
`endif
    // Start pulsed mid-sequence, disabled terminal; also clears the previous err.
    run_seq(1'b1, 16'hF00D, 16'h5555, 1'b0, 16'hF00D, 16'hA700, 16'hF00D, 16'hA700, 1, 1'b1, 1'b0);

    // Reset during the W2 strobe.
    m_a1[0] = 16'h00FF; m_a3[0] = 16'hA6C5;
    dcnt0 = done_cnt;
    start_seq(1'b0, 16'h00FF, 16'h1234, 1'b1, 1);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clk);
      #1;
      if (!bus_wr_n && bus_a == 2'd2) found = 1'b1;
    end
    if (!found) chk("w2_wait", 32'd0, 32'd1);
    abort = 1'b1;
    #1 aclr = 1'b1;
    #1;
    chk("abort_wr_n", 32'(bus_wr_n), 32'd1);
    chk("abort_cs", 32'(bus_cs), 32'hF);
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    aclr = 1'b0;
    exp_q.delete();
    repeat (8) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt - dcnt0), 32'd0);
    run_seq(1'b0, 16'h00FF, 16'h1234, 1'b1, 16'h00FF, 16'hA6C5, 16'h00FF, 16'hA6C5, 1, 1'b0, 1'b0);

    chk("strobe_overlap", 32'(overlap), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
